// File: rtl/frame_fifo_sc_if.sv
// Handshake bundle for frame_fifo_sc: write side, read side, status flags and frame count.
// The producer/consumer logic uses the master modport and the FIFO uses the slave modport.
interface frame_fifo_sc_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 11
);
    logic [DATA_W-1:0] di;
    logic              we;
    logic              EOD_in;
    logic              abort;
    logic              re;
    logic [DATA_W-1:0] do_o;
    logic              EOD_out;
    logic              empty_flag;
    logic              aempty_flag;
    logic              full_flag;
    logic              afull_flag;
    logic [ADDR_W:0]   frame_cnt;
    logic              drop_pulse;

    modport master (
        output di, we, EOD_in, abort, re,
        input  do_o, EOD_out, empty_flag, aempty_flag, full_flag, afull_flag,
               frame_cnt, drop_pulse
    );

    modport slave (
        input  di, we, EOD_in, abort, re,
        output do_o, EOD_out, empty_flag, aempty_flag, full_flag, afull_flag,
               frame_cnt, drop_pulse
    );
endinterface

// File: rtl/frame_fifo_sc.sv
// Single-clock store-and-forward frame FIFO: a frame becomes readable only once its EOD byte
// is written. Supports frame abort, automatic drop of overflowing frames and a frame counter.
module frame_fifo_sc #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned ADDR_W    = 11,
    parameter int unsigned AEMPTY_TH = 4,
    parameter int unsigned AFULL_TH  = 4
) (
    input  logic           clk,
    input  logic           rst,
    frame_fifo_sc_if.slave bus
);
    localparam int unsigned      PTR_W   = ADDR_W + 1;
    localparam int unsigned      DEPTH   = 2 ** ADDR_W;
    localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0] ONE     = PTR_W'(1);

    typedef enum logic [1:0] {StIdle, StFill, StDrop} wr_state_e;

    logic [DATA_W:0]   mem [DEPTH];

    wr_state_e         state_q;
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  wr_cmt_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [PTR_W-1:0]  frame_cnt_q;
    logic [DATA_W-1:0] do_q;
    logic              eod_q;
    logic              drop_q;

    logic [PTR_W-1:0]  used;
    logic [PTR_W-1:0]  avail;
    logic [PTR_W-1:0]  free;
    logic              full;
    logic              empty;
    logic              store;
    logic              commit;
    logic              rd_en;
    logic              rd_eod;
    logic [DATA_W:0]   rd_word;

    // Modulo arithmetic on wrap-bit pointers; used counts uncommitted words too.
    assign used  = wr_ptr_q - rd_ptr_q;
    assign avail = wr_cmt_q - rd_ptr_q;
    assign free  = DEPTH_P - used;
    assign full  = (used == DEPTH_P);
    assign empty = (avail == '0);

    assign store  = bus.we & ~full &
                    ((state_q == StIdle) | ((state_q == StFill) & ~bus.abort));
    assign commit = store & bus.EOD_in;

    assign rd_en   = bus.re & ~empty;
    assign rd_word = mem[rd_ptr_q[ADDR_W-1:0]];
    assign rd_eod  = rd_en & rd_word[DATA_W];

    assign bus.do_o        = do_q;
    assign bus.EOD_out     = eod_q;
    assign bus.drop_pulse  = drop_q;
    assign bus.frame_cnt   = frame_cnt_q;
    assign bus.empty_flag  = empty;
    assign bus.full_flag   = full;
    assign bus.aempty_flag = (avail <= PTR_W'(AEMPTY_TH));
    assign bus.afull_flag  = (free <= PTR_W'(AFULL_TH));

    always_ff @(posedge clk) begin
        if (store) begin
            mem[wr_ptr_q[ADDR_W-1:0]] <= {bus.EOD_in, bus.di};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            wr_ptr_q    <= '0;
            wr_cmt_q    <= '0;
            rd_ptr_q    <= '0;
            frame_cnt_q <= '0;
            do_q        <= '0;
            eod_q       <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            drop_q <= 1'b0;

            if (store) begin
                wr_ptr_q <= wr_ptr_q + ONE;
            end
            if (commit) begin
                wr_cmt_q <= wr_ptr_q + ONE;
            end

            case (state_q)
                StIdle: begin
                    if (bus.we) begin
                        if (full) begin
                            // Byte is lost; a multi-byte frame's remainder must be swallowed.
                            drop_q <= 1'b1;
                            if (!bus.EOD_in) begin
                                state_q <= StDrop;
                            end
                        end else if (!bus.EOD_in) begin
                            state_q <= StFill;
                        end
                    end
                end
                StFill: begin
                    if (bus.abort) begin
                        wr_ptr_q <= wr_cmt_q;
                        drop_q   <= 1'b1;
                        state_q  <= StIdle;
                    end else if (bus.we) begin
                        if (full) begin
                            // If the overflowing byte is the EOD, the frame is already over.
                            wr_ptr_q <= wr_cmt_q;
                            drop_q   <= 1'b1;
                            state_q  <= bus.EOD_in ? StIdle : StDrop;
                        end else if (bus.EOD_in) begin
                            state_q <= StIdle;
                        end
                    end
                end
                StDrop: begin
                    if (bus.abort || (bus.we && bus.EOD_in)) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase

            if (rd_en) begin
                rd_ptr_q <= rd_ptr_q + ONE;
                do_q     <= rd_word[DATA_W-1:0];
                eod_q    <= rd_word[DATA_W];
            end

            if (commit && !rd_eod) begin
                frame_cnt_q <= frame_cnt_q + ONE;
            end else if (!commit && rd_eod) begin
                frame_cnt_q <= frame_cnt_q - ONE;
            end
        end
    end
endmodule

// File: tb/tb_frame_fifo_sc.sv
// Self-checking bench for frame_fifo_sc (DEPTH=16): a frame-level reference model fills a
// scoreboard queue on commit and every cycle compares data, flags and frame count.
module tb_frame_fifo_sc;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 4;
    localparam int          DEPTH  = 16;
    localparam int          TH     = 4;

    typedef enum int {MIdle, MFill, MDrop} mst_e;

    logic clk = 1'b0;
    logic rst;

    frame_fifo_sc_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    frame_fifo_sc #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .AEMPTY_TH(TH),
        .AFULL_TH (TH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int         n_vec = 0;
    int         n_err = 0;
    mst_e       mst;
    logic [8:0] exp_q[$];
    logic [8:0] pend_q[$];
    logic [7:0] m_do;
    logic       m_eod;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic int m_frames();
        int n = 0;
        foreach (exp_q[i]) if (exp_q[i][8]) n++;
        return n;
    endfunction

    task automatic m_commit();
        foreach (pend_q[i]) exp_q.push_back(pend_q[i]);
        pend_q.delete();
    endtask

    task automatic model_reset();
        mst = MIdle;
        exp_q.delete();
        pend_q.delete();
        m_do  = '0;
        m_eod = 1'b0;
    endtask

    task automatic check_reset_vals();
        check_eq("rst_do", 32'(bus.do_o), 0);
        check_eq("rst_eod", 32'(bus.EOD_out), 0);
        check_eq("rst_empty", 32'(bus.empty_flag), 1);
        check_eq("rst_aempty", 32'(bus.aempty_flag), 1);
        check_eq("rst_full", 32'(bus.full_flag), 0);
        check_eq("rst_afull", 32'(bus.afull_flag), 0);
        check_eq("rst_cnt", 32'(bus.frame_cnt), 0);
        check_eq("rst_drop", 32'(bus.drop_pulse), 0);
    endtask

    // One clock: drive inputs, predict from pre-edge model state, compare #1 after the edge.
    task automatic step(input logic w, input logic e, input logic [7:0] d,
                        input logic r, input logic a);
        int         used;
        bit         mfull;
        bit         mdrop;
        logic [8:0] word;
        bus.we = w; bus.EOD_in = e; bus.di = d; bus.re = r; bus.abort = a;
        used  = exp_q.size() + pend_q.size();
        mfull = (used == DEPTH);
        mdrop = 1'b0;
        if (r && exp_q.size() != 0) begin
            word  = exp_q.pop_front();
            m_do  = word[7:0];
            m_eod = word[8];
        end
        case (mst)
            MIdle: if (w) begin
                if (mfull) begin
                    mdrop = 1'b1;
                    if (!e) mst = MDrop;
                end else begin
                    pend_q.push_back({e, d});
                    if (e) m_commit(); else mst = MFill;
                end
            end
            MFill: if (a) begin
                pend_q.delete(); mdrop = 1'b1; mst = MIdle;
            end else if (w) begin
                if (mfull) begin
                    pend_q.delete(); mdrop = 1'b1; mst = e ? MIdle : MDrop;
                end else begin
                    pend_q.push_back({e, d});
                    if (e) begin m_commit(); mst = MIdle; end
                end
            end
            MDrop: if (a || (w && e)) mst = MIdle;
            default: mst = MIdle;
        endcase
        @(posedge clk);
        #1;
        used = exp_q.size() + pend_q.size();
        check_eq("do_o", 32'(bus.do_o), 32'(m_do));
        check_eq("eod_out", 32'(bus.EOD_out), 32'(m_eod));
        check_eq("drop_pulse", 32'(bus.drop_pulse), 32'(mdrop));
        check_eq("empty", 32'(bus.empty_flag), 32'(exp_q.size() == 0));
        check_eq("full", 32'(bus.full_flag), 32'(used == DEPTH));
        check_eq("aempty", 32'(bus.aempty_flag), 32'(exp_q.size() <= TH));
        check_eq("afull", 32'(bus.afull_flag), 32'((DEPTH - used) <= TH));
        check_eq("frame_cnt", 32'(bus.frame_cnt), 32'(m_frames()));
        bus.we = 1'b0; bus.EOD_in = 1'b0; bus.re = 1'b0; bus.abort = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) step(0, 0, 8'h00, 1, 0);
        check_eq("drained", 32'(bus.empty_flag), 1);
    endtask

    initial begin
        rst = 1'b1;
        bus.we = 1'b0; bus.EOD_in = 1'b0; bus.di = '0; bus.re = 1'b0; bus.abort = 1'b0;
        model_reset();
        #2;
        check_reset_vals();
        #5 rst = 1'b0;

        // Basic frame: not readable until the EOD write lands.
        for (int i = 1; i <= 5; i++) begin
            step(1, i == 5, 8'(i), 0, 0);
            if (i == 4) check_eq("t1_empty_pre_eod", 32'(bus.empty_flag), 1);
        end
        check_eq("t1_cnt", 32'(bus.frame_cnt), 1);
        for (int i = 1; i <= 5; i++) begin
            step(0, 0, 8'h00, 1, 0);
            check_eq("t1_data", 32'(bus.do_o), 32'(i));
        end
        check_eq("t1_last_eod", 32'(bus.EOD_out), 1);
        step(0, 0, 8'h00, 1, 0);  // read while empty must hold do_o

        // Abort mid-frame, then a clean frame.
        step(1, 0, 8'h31, 0, 0);
        step(1, 0, 8'h32, 0, 0);
        step(1, 0, 8'h33, 0, 0);
        step(0, 0, 8'h00, 0, 1);
        check_eq("t2_abort_drop", 32'(bus.drop_pulse), 1);
        step(1, 0, 8'hAA, 0, 0);
        step(1, 1, 8'hBB, 0, 0);
        check_eq("t2_cnt", 32'(bus.frame_cnt), 1);
        drain();

        // Overflowing 20-byte frame is dropped on byte 17.
        for (int i = 0; i < 20; i++) begin
            step(1, i == 19, 8'(8'h40 + i), 0, 0);
            if (i == 15) check_eq("t3_full16", 32'(bus.full_flag), 1);
            if (i == 16) check_eq("t3_drop17", 32'(bus.drop_pulse), 1);
        end
        check_eq("t3_cnt", 32'(bus.frame_cnt), 0);
        check_eq("t3_empty", 32'(bus.empty_flag), 1);
        check_eq("t3_afull", 32'(bus.afull_flag), 0);
        step(1, 1, 8'h5A, 0, 0);  // FIFO usable again after the drop
        drain();

        // Concurrent write/read across pointer wrap, 8-byte frames.
        for (int i = 0; i < 3 * DEPTH; i++) step(1, (i % 8) == 7, 8'(8'h80 + i), 1, 0);
        drain();

        // Commit and EOD read in the same cycle.
        step(1, 0, 8'h10, 0, 0);
        step(1, 1, 8'h11, 0, 0);
        step(1, 0, 8'h20, 0, 0);
        step(0, 0, 8'h00, 1, 0);
        step(1, 1, 8'h21, 1, 0);
        check_eq("t5_cnt_hold", 32'(bus.frame_cnt), 1);
        check_eq("t5_eod_read", 32'(bus.EOD_out), 1);
        drain();
        // Threshold edges: afull at 12 used, aempty at 4 committed.
        for (int i = 0; i < 15; i++) begin
            step(1, i == 14, 8'(8'hC0 + i), 0, 0);
            if (i == 10) check_eq("t5_afull_11", 32'(bus.afull_flag), 0);
            if (i == 11) check_eq("t5_afull_12", 32'(bus.afull_flag), 1);
        end
        for (int i = 0; i < 15; i++) begin
            step(0, 0, 8'h00, 1, 0);
            if (i == 9)  check_eq("t5_aempty_5", 32'(bus.aempty_flag), 0);
            if (i == 10) check_eq("t5_aempty_4", 32'(bus.aempty_flag), 1);
        end

        // Asynchronous reset with two committed frames and one partial.
        step(1, 0, 8'hD0, 0, 0);
        step(1, 1, 8'hD1, 0, 0);
        step(1, 0, 8'hE0, 0, 0);
        step(1, 1, 8'hE1, 0, 0);
        step(0, 0, 8'h00, 1, 0);
        step(1, 0, 8'hF0, 0, 0);
        step(1, 0, 8'hF1, 0, 0);
        check_eq("t6_cnt_pre", 32'(bus.frame_cnt), 2);
        #2 rst = 1'b1;
        #1;
        check_reset_vals();
        model_reset();
        #3 rst = 1'b0;
        step(1, 0, 8'h61, 0, 0);
        step(1, 0, 8'h62, 0, 0);
        step(1, 1, 8'h63, 0, 0);
        check_eq("t6_cnt_post", 32'(bus.frame_cnt), 1);
        drain();
        check_eq("t6_last", 32'(bus.do_o), 32'h63);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
